moving_average_interp: RTL and testbench
========================================

# moving_average_interp

Interpolating expander that takes decimated moving-average sums and turns them back into a full-rate sample stream. Each accepted input word is the sum of 2^k raw samples, as produced by the decimating accumulator on the ADC path. The block normalizes it by 2^k and emits 2^k output beats. It sits on the playback/test-injection path feeding 12-bit consumers (DAC model, loopback checker) through a valid/ready handshake.

## Interface
Parameters:
- IN_DATA_WIDTH, 16, width of the accumulated input sum
- OUT_DATA_WIDTH, 12, width of the reconstructed output sample

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- interp_log2  in  3  k, expansion ratio R = 2^k (1..128); sampled only at input acceptance
- in_data_valid  in  1  input word present
- in_data_ready  out  1  block can accept input
- in_data  in  IN_DATA_WIDTH  unsigned sum of R samples
- out_data_valid  out  1  output beat present
- out_data_ready  in  1  consumer accepts beat
- out_data  out  OUT_DATA_WIDTH  reconstructed sample
- busy  out  1  burst in progress (state EMIT)

## Operation
- States: IDLE, EMIT. Reset → IDLE.
- IDLE:
  - in_data_ready = 1 (combinational: state==IDLE and !rst).
  - On in_data_valid & in_data_ready:
    - latch k_lat = interp_log2.
    - m_cur = in_data >> k_lat, saturated to 2^OUT_DATA_WIDTH-1.
    - beat counter cnt = 0.
    - go to EMIT.
- EMIT:
  - in_data_ready = 0, out_data_valid = 1.
  - out_data is registered and held stable while out_data_valid & !out_data_ready.
  - On out_data_valid & out_data_ready:
    - if cnt == R-1, go to IDLE (out_data_valid deasserts next cycle).
    - else cnt++ and load the next beat value.
- Beat value, zero-order hold: every beat = m_cur.
- k_lat governs the whole burst. interp_log2 changes during EMIT have no effect until the next acceptance.
- cnt width is 8 bits; R-1 max is 127, so cnt does not wrap.
- Reset mid-burst:
  - abort immediately; remaining beats are discarded.
  - out_data_valid = 0, out_data = 0, and m_prev/m_cur = 0 (linear mode).

## Timing
- Reset values: out_data_valid 0, out_data 0, busy 0, in_data_ready 0 while rst is high.
- Latency: input accepted at edge N → first beat valid from edge N (visible in cycle N+1).
- With out_data_ready held high, one beat per cycle. The last handshake is at edge N+R; state is IDLE and in_data_ready = 1 in the following cycle.
- Throughput: one input per R+1 cycles at best. There is no overlap of acceptance with the final beat.
- Back-pressure stretches EMIT indefinitely with no data loss.

## Configuration
- LINEAR_INTERP_EN defined:
  - The block keeps m_prev (reset 0).
  - Beat i (0..R-1) = m_prev + (((m_cur - m_prev) * (i+1)) >>> k_lat).
  - The difference is signed, OUT_DATA_WIDTH+1 bits; the product is OUT_DATA_WIDTH+9 bits; the shift is arithmetic.
  - The last beat equals m_cur exactly.
  - On burst completion, m_prev <= m_cur. An aborted burst does not update m_prev.
- LINEAR_INTERP_EN undefined: zero-order hold only. No m_prev register and no multiplier are synthesized.

## Test plan
- k=2, in_data=0x0800, out_data_ready=1 → four beats of 0x200 on consecutive cycles, then in_data_ready=1 on the next cycle, busy low.
- k=0, in_data=0x1234 → single beat 0xFFF (saturated); in_data_ready returns after 2 cycles total.
- k=3, in_data=0x0400, out_data_ready toggled 1,0,0,1,… → eight beats of 0x080; out_data stable during stalls; no beat lost or duplicated.
- Start k=1 burst, set interp_log2=4 during EMIT → exactly 2 beats; next input uses k=4 (16 beats).
- Reset asserted on the 3rd beat of a k=3 burst → out_data_valid=0 and out_data=0 the next cycle. After release, in_data_ready=1 and a new burst starts cleanly.
- LINEAR_INTERP_EN, k=2: first input 0x0640 (mean 400) → 100, 200, 300, 400. Then input 0x0000 → 300, 200, 100, 0.

Source files
------------

// File: rtl/moving_average_interp.sv
// moving_average_interp
// Interpolating expander: each accepted input word is the sum of 2^k raw
// samples; it is normalised by 2^k (saturated to the output width) and
// replayed as 2^k output beats over a valid/ready handshake.
//
// Optional build macro:
//   LINEAR_INTERP_EN - beats ramp linearly from the previous burst mean to
//                      the current one instead of a zero-order hold.
//                      Leaving it undefined drops the m_prev register and
//                      the multiplier entirely.
//
// Assumes IN_DATA_WIDTH >= OUT_DATA_WIDTH.
module moving_average_interp #(
   parameter int IN_DATA_WIDTH  = 16,
   parameter int OUT_DATA_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2:0]                interp_log2,
   input  logic                      in_data_valid,
   output logic                      in_data_ready,
   input  logic [IN_DATA_WIDTH-1:0]  in_data,
   output logic                      out_data_valid,
   input  logic                      out_data_ready,
   output logic [OUT_DATA_WIDTH-1:0] out_data,
   output logic                      busy
);

   localparam logic [IN_DATA_WIDTH-1:0] SAT_MAX =
      IN_DATA_WIDTH'((2 ** OUT_DATA_WIDTH) - 1);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   state_e                    state_q, state_d;
   logic [2:0]                k_lat_q, k_lat_d;
   logic [7:0]                cnt_q, cnt_d;
   logic [OUT_DATA_WIDTH-1:0] m_cur_q, m_cur_d;
   logic [OUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                      out_valid_q, out_valid_d;

   logic                      accept;
   logic [7:0]                last_cnt;
   logic [IN_DATA_WIDTH-1:0]  in_shifted;
   logic [OUT_DATA_WIDTH-1:0] mean_in;
   logic [OUT_DATA_WIDTH-1:0] beat_m;
   logic [OUT_DATA_WIDTH-1:0] beat_value;

   assign in_data_ready  = (state_q == IDLE) && !rst;
   assign accept         = in_data_valid && (state_q == IDLE);
   assign out_data_valid = out_valid_q;
   assign out_data       = out_data_q;
   assign busy           = (state_q == EMIT);
   assign last_cnt       = (8'd1 << k_lat_q) - 8'd1;

   // Normalise the incoming sum by 2^k and clamp to the output range.
   always_comb begin
      in_shifted = in_data >> interp_log2;
      mean_in    = (in_shifted > SAT_MAX) ? {OUT_DATA_WIDTH{1'b1}}
                                          : in_shifted[OUT_DATA_WIDTH-1:0];
   end

   // The beat being loaded is beat 0 of a new burst on acceptance,
   // otherwise the beat after the one currently presented.
   assign beat_m = accept ? mean_in : m_cur_q;

`ifdef LINEAR_INTERP_EN
   localparam int PROD_W = OUT_DATA_WIDTH + 9;

   logic [OUT_DATA_WIDTH-1:0]      m_prev_q, m_prev_d;
   logic [2:0]                     beat_k;
   logic [7:0]                     beat_step;
   logic signed [OUT_DATA_WIDTH:0] diff;
   logic signed [PROD_W-1:0]       prod;
   logic signed [PROD_W-1:0]       ramp;
   logic signed [PROD_W-1:0]       beat_full;

   // Linear ramp: m_prev + ((m_cur - m_prev) * (i+1)) >>> k; beat R-1 lands on m_cur.
   always_comb begin
      beat_k    = accept ? interp_log2 : k_lat_q;
      beat_step = accept ? 8'd1 : (cnt_q + 8'd2);
      diff      = $signed({1'b0, beat_m}) - $signed({1'b0, m_prev_q});
      prod      = $signed({{8{diff[OUT_DATA_WIDTH]}}, diff})
                * $signed({{(PROD_W-8){1'b0}}, beat_step});
      ramp      = prod >>> beat_k;
      beat_full = $signed({{9{1'b0}}, m_prev_q}) + ramp;
      beat_value = OUT_DATA_WIDTH'(beat_full);
   end
`else
   assign beat_value = beat_m;
`endif

   // Next-state logic for the IDLE/EMIT controller and its datapath.
   always_comb begin
      // NOTE: every _d gets a hold default first so no path through the
      // case statement leaves it unassigned (which would infer a latch).
      state_d     = state_q;
      k_lat_d     = k_lat_q;
      cnt_d       = cnt_q;
      m_cur_d     = m_cur_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
`ifdef LINEAR_INTERP_EN
      m_prev_d    = m_prev_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_data_valid) begin
               k_lat_d     = interp_log2;
               m_cur_d     = mean_in;
               cnt_d       = 8'd0;
               out_data_d  = beat_value;
               out_valid_d = 1'b1;
               state_d     = EMIT;
            end
         end
         EMIT: begin
            if (out_data_ready) begin
               if (cnt_q == last_cnt) begin
                  out_valid_d = 1'b0;
                  state_d     = IDLE;
`ifdef LINEAR_INTERP_EN
                  m_prev_d    = m_cur_q;
`endif
               end else begin
                  cnt_d      = cnt_q + 8'd1;
                  out_data_d = beat_value;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; synchronous reset aborts any burst and zeroes the datapath.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= IDLE;
         k_lat_q     <= '0;
         cnt_q       <= '0;
         m_cur_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
`ifdef LINEAR_INTERP_EN
         m_prev_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         k_lat_q     <= k_lat_d;
         cnt_q       <= cnt_d;
         m_cur_q     <= m_cur_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
`ifdef LINEAR_INTERP_EN
         m_prev_q    <= m_prev_d;
`endif
      end
   end

endmodule

// File: tb/tb_moving_average_interp.sv
// Self-checking bench for moving_average_interp: directed scenarios plus
// randomised bursts scored against a behavioural model of the expander.
// Build with +define+LINEAR_INTERP_EN to exercise the linear-ramp variant.
module tb_moving_average_interp;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  interp;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int exp_q[$];
   int last_obs[$];
   int beats_seen   = 0;
   int m_prev_model = 0;
   int burst_cur    = 0;
   bit prev_stall   = 0;
   logic [11:0] prev_data;

   int ready_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
   int pat_idx    = 0;

   moving_average_interp #(
      .IN_DATA_WIDTH (16),
      .OUT_DATA_WIDTH(12)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .interp_log2   (interp),
      .in_data_valid (in_valid),
      .in_data_ready (in_ready),
      .in_data       (in_data),
      .out_data_valid(out_valid),
      .out_data_ready(out_ready),
      .out_data      (out_data),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic finish_test();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   // Expected beats for one accepted word, from the block's arithmetic rules.
   function automatic void model_accept(input int k, input int data);
      int r;
      int mean;
      int q;
      int b;
      r    = 1 << k;
      mean = data / r;
      if (mean > 4095) mean = 4095;
      burst_cur = mean;
      for (int i = 0; i < r; i++) begin
`ifdef LINEAR_INTERP_EN
         q = (mean - m_prev_model) * (i + 1);
         if (q >= 0) b = m_prev_model + q / r;
         else        b = m_prev_model - ((-q + r - 1) / r);   // floor division
`else
         q = 0;
         b = mean;
`endif
         exp_q.push_back(b);
      end
   endfunction

   // Output-ready driver
   always begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1: begin out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3); pat_idx++; end
         default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
   end

   // Monitor / scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_prev_model = 0;
         prev_stall   = 0;
      end else begin
         check("valid_busy", out_valid, busy);
         check("ready_idle", in_ready, !busy);
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_hold", out_data, prev_data);
         end
         if (in_valid && in_ready) begin
            model_accept(int'(interp), int'(in_data));
            last_obs.delete();
            beats_seen = 0;
         end
         if (out_valid && out_ready) begin
            check("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               check("beat_value", out_data, exp_q.pop_front());
               if (exp_q.size() == 0) m_prev_model = burst_cur;
            end
            last_obs.push_back(int'(out_data));
            beats_seen++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   // Offer one word; returns one step after the accepting edge.
   task automatic send(input int k, input int data, input int k_after);
      int n;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 16'(data);
      interp   = 3'(k);
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 3000) begin
            check("accept_timeout", in_ready, 1);
            finish_test();
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      interp   = 3'(k_after);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(in_ready && exp_q.size() == 0) && n < 3000);
      if (n >= 3000) begin
         check("idle_timeout", in_ready, 1);
         finish_test();
      end
   endtask

   // Burst with out_data_ready held high: measure cycles until in_data_ready returns.
   task automatic timed_burst(input int k, input int data, input int exp_cycles);
      int cycles;
      send(k, data, k);
      @(negedge clk);
      cycles = 1;
      check("first_beat_valid", out_valid, 1);
      check("first_beat_busy", busy, 1);
      while (!in_ready && cycles < 300) begin
         @(negedge clk);
         cycles++;
      end
      check("ready_latency", cycles, exp_cycles);
      check("busy_after", busy, 0);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      interp   = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", in_ready, 1);

`ifdef LINEAR_INTERP_EN
      // Linear ramp up from 0 to 400, then back down to 0
      send(2, 16'h0640, 2);
      wait_idle();
      check("lin_up_count", beats_seen, 4);
      for (int i = 0; i < 4; i++) check("lin_up_beat", last_obs[i], 100 * (i + 1));
      send(2, 16'h0000, 2);
      wait_idle();
      check("lin_dn_count", beats_seen, 4);
      for (int i = 0; i < 4; i++) check("lin_dn_beat", last_obs[i], 300 - 100 * i);
`endif

      // k=2, 0x0800: four beats, IDLE again after 5 cycles
      ready_mode = 0;
      timed_burst(2, 16'h0800, 5);
      check("k2_count", beats_seen, 4);
      check("k2_last", last_obs[3], 12'h200);
`ifndef LINEAR_INTERP_EN
      for (int i = 0; i < 4; i++) check("k2_beat", last_obs[i], 12'h200);
`endif

      // k=0, 0x1234: single saturated beat
      timed_burst(0, 16'h1234, 2);
      check("k0_count", beats_seen, 1);
      check("k0_sat", last_obs[0], 12'hFFF);

      // k=3 with back-pressure pattern 1,0,0,1
      ready_mode = 1;
      send(3, 16'h0400, 3);
      wait_idle();
      ready_mode = 0;
      check("k3_bp_count", beats_seen, 8);
      check("k3_bp_last", last_obs[7], 12'h080);
`ifndef LINEAR_INTERP_EN
      for (int i = 0; i < 8; i++) check("k3_bp_beat", last_obs[i], 12'h080);
`endif

      // interp_log2 changed during EMIT only affects the next burst
      send(1, 16'h0300, 4);
      wait_idle();
      check("klat_count", beats_seen, 2);
      check("klat_last", last_obs[1], 12'h180);
      send(4, 16'h8000, 4);
      wait_idle();
      check("k4_count", beats_seen, 16);
      check("k4_last", last_obs[15], 12'h800);

      // Reset on the 3rd beat of a k=3 burst
      send(3, 16'h0400, 3);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("abort_beats", beats_seen, 2);
      check("abort_valid", out_valid, 0);
      check("abort_data", out_data, 0);
      check("abort_busy", busy, 0);
      check("abort_ready_in_rst", in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_ready", in_ready, 1);
      timed_burst(1, 16'h0100, 3);
      check("post_abort_count", beats_seen, 2);
      check("post_abort_last", last_obs[1], 12'h080);

      // Randomised bursts with random back-pressure and mid-burst k changes
      ready_mode = 2;
      for (int n = 0; n < 30; n++) begin
         int k;
         int data;
         k    = $urandom_range(0, 5);
         data = $urandom_range(0, 16'hFFFF) >> $urandom_range(0, 4);
         send(k, data, $urandom_range(0, 7));
         wait_idle();
         check("rand_count", beats_seen, 1 << k);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      check("queue_empty", exp_q.size(), 0);
      finish_test();
   end

endmodule
